prog_sequencer: RTL and testbench

Program sequencer that feeds the simple processor from a synchronous program ROM. It fetches 9-bit instruction words, presents them on the processor's `Din` bus, and generates `run` pulses, including the second word of two-word `mvi` instructions. It then waits for `Done` before moving on. It sits between the program memory and the processor control unit, replacing the manual switch/`run` stimulus, and reports busy, halted and error status.

---
 rtl/proc_pkg.sv | 41 ++++
 rtl/seq_watchdog.sv | 30 +++
 rtl/prog_sequencer.sv | 113 +++++++++++
 tb/tb_prog_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor and its program sequencer:
// opcode field values and the sequencer state encoding.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [3:0] SEQ_IDLE      = 4'd0;
  localparam logic [3:0] SEQ_FETCH     = 4'd1;
  localparam logic [3:0] SEQ_DECODE    = 4'd2;
  localparam logic [3:0] SEQ_PRESENT   = 4'd3;
  localparam logic [3:0] SEQ_ISSUE     = 4'd4;
  localparam logic [3:0] SEQ_IMM_FETCH = 4'd5;
  localparam logic [3:0] SEQ_IMM_LOAD  = 4'd6;
  localparam logic [3:0] SEQ_IMM_ISSUE = 4'd7;
  localparam logic [3:0] SEQ_WAIT_DONE = 4'd8;
  localparam logic [3:0] SEQ_HALTED    = 4'd9;
  localparam logic [3:0] SEQ_ERR       = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE      = SEQ_IDLE,
    S_FETCH     = SEQ_FETCH,
    S_DECODE    = SEQ_DECODE,
    S_PRESENT   = SEQ_PRESENT,
    S_ISSUE     = SEQ_ISSUE,
    S_IMM_FETCH = SEQ_IMM_FETCH,
    S_IMM_LOAD  = SEQ_IMM_LOAD,
    S_IMM_ISSUE = SEQ_IMM_ISSUE,
    S_WAIT_DONE = SEQ_WAIT_DONE,
    S_HALTED    = SEQ_HALTED,
    S_ERR       = SEQ_ERR
  } seq_state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op inside {OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_HALT};
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle counter that flags a timeout once MAX enabled cycles pass; clear
// restarts the count.
module seq_watchdog #(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !timeout) begin
      count <= count + 1'b1;
    end
  end

  // Asserted during the MAX-th enabled cycle so the owner leaves right after it.
  assign timeout = enable && (count == CW'(MAX - 1));

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: fetches ROM words, drives processor Din/run, waits for Done.
// Optional WAIT_DONE watchdog enabled by defining SEQ_WATCHDOG_EN.
module prog_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned WDOG_MAX = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [8:0]        mem_rdata,
  output logic [8:0]        proc_din,
  output logic              proc_run,
  input  logic              proc_done,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [7:0]        icount
);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [8:0]        din_reg;
  logic [2:0]        rd_op;
  logic              timeout;

  assign rd_op = mem_rdata[8:6];

`ifdef SEQ_WATCHDOG_EN
  seq_watchdog #(.MAX(WDOG_MAX)) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (state != S_WAIT_DONE),
    .enable  (state == S_WAIT_DONE),
    .timeout (timeout)
  );
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_MAX;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_HALTED, S_ERR: if (start) state_nxt = S_FETCH;
      S_FETCH:                 state_nxt = S_DECODE;
      S_DECODE: begin
        if (rd_op == OP_HALT)        state_nxt = S_HALTED;
        else if (!op_is_legal(rd_op)) state_nxt = S_ERR;
        else                          state_nxt = S_PRESENT;
      end
      S_PRESENT:               state_nxt = S_ISSUE;
      // pc already advanced past the opcode word; zero means the immediate would wrap.
      S_ISSUE: begin
        if (din_reg[8:6] == OP_MVI) state_nxt = (pc == '0) ? S_ERR : S_IMM_FETCH;
        else                        state_nxt = S_WAIT_DONE;
      end
      S_IMM_FETCH:             state_nxt = S_IMM_LOAD;
      S_IMM_LOAD:              state_nxt = S_IMM_ISSUE;
      S_IMM_ISSUE:             state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (proc_done)    state_nxt = (pc == '0) ? S_HALTED : S_FETCH;
        else if (timeout) state_nxt = S_ERR;
      end
      default:                 state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      pc      <= '0;
      din_reg <= '0;
      icount  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_HALTED, S_ERR: begin
          if (start) begin
            pc     <= '0;
            icount <= '0;
          end
        end
        S_DECODE: begin
          if (op_is_legal(rd_op) && rd_op != OP_HALT) begin
            din_reg <= mem_rdata;
            pc      <= pc + 1'b1;
          end
        end
        S_IMM_LOAD: begin
          din_reg <= mem_rdata;
          pc      <= pc + 1'b1;
        end
        S_WAIT_DONE: begin
          if (proc_done && icount != '1) icount <= icount + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = pc;
  assign proc_din = din_reg;
  assign proc_run = (state == S_ISSUE) || (state == S_IMM_ISSUE);
  assign busy     = !(state inside {S_IDLE, S_HALTED, S_ERR});
  assign halted   = (state == S_HALTED);
  assign err      = (state == S_ERR);

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a synchronous ROM and a small
// behavioural model of the processor's register file and Done timing.
module tb_prog_sequencer;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [8:0]    mem_rdata;
  logic [8:0]    proc_din;
  logic          proc_run;
  logic          proc_done;
  logic          busy;
  logic          halted;
  logic          err;
  logic [7:0]    icount;

  logic [8:0]    rom [32];
  int            checks   = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  prog_sequencer #(.ADDR_W(AW), .WDOG_MAX(15)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .proc_din  (proc_din),
    .proc_run  (proc_run),
    .proc_done (proc_done),
    .busy      (busy),
    .halted    (halted),
    .err       (err),
    .icount    (icount)
  );

  always @(posedge clk) mem_rdata <= rom[mem_addr];

  // Processor model: mv done 1 cycle after run, add/sub 3, mvi after its second run.
  logic [8:0] r [8];
  logic       mvi_pend;
  logic [2:0] mvi_rx;
  int         done_cnt;
  logic       stuck;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mvi_pend <= 1'b0;
      mvi_rx   <= '0;
      done_cnt <= 0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else if (proc_run) begin
      if (mvi_pend) begin
        r[mvi_rx] <= proc_din;
        mvi_pend  <= 1'b0;
        done_cnt  <= 1;
      end else begin
        case (proc_din[8:6])
          3'b000: begin r[proc_din[5:3]] <= r[proc_din[2:0]]; done_cnt <= 1; end
          3'b001: begin mvi_pend <= 1'b1; mvi_rx <= proc_din[5:3]; end
          3'b010: begin r[proc_din[5:3]] <= r[proc_din[5:3]] + r[proc_din[2:0]]; done_cnt <= 3; end
          3'b011: begin r[proc_din[5:3]] <= r[proc_din[5:3]] - r[proc_din[2:0]]; done_cnt <= 3; end
          default: ;
        endcase
      end
    end else if (done_cnt != 0) begin
      done_cnt <= done_cnt - 1;
    end
  end

  assign proc_done = !stuck && (done_cnt == 1);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         run_cnt = 0;
  logic       prev_run = 1'b0;
  logic [8:0] din_prev = '0;

  always @(negedge clk) begin
    if (proc_run) begin
      run_cnt++;
      check("run_gap", {31'd0, prev_run}, 0);
      if (!mvi_pend) check("din_stable", {23'd0, proc_din}, {23'd0, din_prev});
    end
    prev_run = proc_run;
    din_prev = proc_din;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_stop(input int budget, output int cyc);
    cyc = 0;
    while (!(halted || err) && cyc < budget) begin
      tick();
      cyc++;
    end
    check("stop_reached", {31'd0, halted | err}, 1);
  endtask

  task automatic fill_rom(input logic [8:0] w);
    for (int i = 0; i < 32; i++) rom[i] = w;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  int         cyc;
  int         lat;
  logic [8:0] run_din;
  logic [8:0] done_din;

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    stuck  = 1'b0;
    fill_rom(9'h1C0);
    #12;
    check("rst_busy",  {31'd0, busy}, 0);
    check("rst_run",   {31'd0, proc_run}, 0);
    check("rst_flags", {30'd0, halted, err}, 0);
    check("rst_addr",  {27'd0, mem_addr}, 0);
    check("rst_din",   {23'd0, proc_din}, 0);
    check("rst_icnt",  {24'd0, icount}, 0);
    resetn = 1'b1;
    tick();

    // mvi R0,5; mvi R1,3; add R0,R1; halt
    rom[0] = 9'h040; rom[1] = 9'h005; rom[2] = 9'h048;
    rom[3] = 9'h003; rom[4] = 9'h081; rom[5] = 9'h1C0;
    run_cnt = 0;
    start = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      start = 1'b0;
    end while (!proc_run && lat < 20);
    check("latency", lat, 4);
    pulse_start();
    check("start_busy_ignored", {31'd0, busy}, 1);
    wait_stop(200, cyc);
    check("p1_cycles", 5 + cyc, 26);
    check("p1_halted", {31'd0, halted}, 1);
    check("p1_err",    {31'd0, err}, 0);
    check("p1_icount", {24'd0, icount}, 3);
    check("p1_r0",     {23'd0, r[0]}, 8);
    check("p1_r1",     {23'd0, r[1]}, 3);
    check("p1_runs",   run_cnt, 5);
    check("p1_addr",   {27'd0, mem_addr}, 5);

    // mv R1,R0; halt
    fill_rom(9'h1C0);
    rom[0] = 9'h008;
    run_cnt  = 0;
    run_din  = '0;
    done_din = '0;
    pulse_start();
    cyc = 0;
    while (!(halted || err) && cyc < 100) begin
      tick();
      cyc++;
      if (proc_run)  run_din  = proc_din;
      if (proc_done) done_din = proc_din;
    end
    check("p2_runs",     run_cnt, 1);
    check("p2_run_din",  {23'd0, run_din}, 9'h008);
    check("p2_done_din", {23'd0, done_din}, 9'h008);
    check("p2_held_din", {23'd0, proc_din}, 9'h008);
    check("p2_icount",   {24'd0, icount}, 1);
    check("p2_r1",       {23'd0, r[1]}, 8);
    check("p2_halted",   {31'd0, halted}, 1);

    // illegal opcode at address 0, then restart after fixing the ROM
    rom[0] = 9'h100;
    run_cnt = 0;
    pulse_start();
    tick();
    check("ill_decode_err", {31'd0, err}, 0);
    tick();
    check("ill_err",    {31'd0, err}, 1);
    check("ill_busy",   {31'd0, busy}, 0);
    check("ill_halted", {31'd0, halted}, 0);
    check("ill_runs",   run_cnt, 0);
    rom[0] = 9'h008;
    pulse_start();
    check("ill_restart_err", {31'd0, err}, 0);
    wait_stop(100, cyc);
    check("ill_fixed_halted", {31'd0, halted}, 1);
    check("ill_fixed_err",    {31'd0, err}, 0);
    check("ill_fixed_icount", {24'd0, icount}, 1);

    // whole ROM of mv: runs off the end and halts with pc wrapped
    fill_rom(9'h008);
    run_cnt = 0;
    pulse_start();
    wait_stop(400, cyc);
    check("wrap_cycles", 1 + cyc, 161);
    check("wrap_halted", {31'd0, halted}, 1);
    check("wrap_icount", {24'd0, icount}, 32);
    check("wrap_addr",   {27'd0, mem_addr}, 0);
    check("wrap_runs",   run_cnt, 32);

    // Done never arrives
    stuck = 1'b1;
    pulse_start();
    lat = 0;
    while (!proc_run && lat < 10) begin
      tick();
      lat++;
    end
    check("stuck_run_seen", {31'd0, proc_run}, 1);
`ifdef SEQ_WATCHDOG_EN
    lat = 0;
    while (!err && lat < 40) begin
      tick();
      lat++;
    end
    check("wdog_cycles", lat, 16);
    check("wdog_err",    {31'd0, err}, 1);
`else
    repeat (40) tick();
    check("stuck_busy", {31'd0, busy}, 1);
    check("stuck_err",  {31'd0, err}, 0);
`endif
    stuck  = 1'b0;
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    tick();

    // reset asserted during IMM_LOAD
    fill_rom(9'h1C0);
    rom[0] = 9'h040;
    rom[1] = 9'h005;
    pulse_start();
    repeat (5) tick();
    check("imm_busy", {31'd0, busy}, 1);
    check("imm_addr", {27'd0, mem_addr}, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_busy",  {31'd0, busy}, 0);
    check("arst_addr",  {27'd0, mem_addr}, 0);
    check("arst_din",   {23'd0, proc_din}, 0);
    check("arst_run",   {31'd0, proc_run}, 0);
    check("arst_flags", {30'd0, halted, err}, 0);
    start = 1'b1;
    tick();
    tick();
    check("arst_start_ignored", {31'd0, busy}, 0);
    resetn = 1'b1;
    start  = 1'b0;
    tick();
    check("arst_idle", {31'd0, busy}, 0);
    pulse_start();
    wait_stop(100, cyc);
    check("post_rst_r0",     {23'd0, r[0]}, 5);
    check("post_rst_icount", {24'd0, icount}, 1);
    check("post_rst_halted", {31'd0, halted}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
